// File: rtl/mem_request_queue_if.sv
// mem_request_queue_if -- request handshake bundle for mem_request_queue.
//
// Carries the two valid/ready channels of the queue:
//   in_valid / in_opcode / in_address / in_ready     parser -> queue
//   out_valid / out_opcode / out_address / out_ready queue -> scheduler
//
// Modports:
//   master : the environment around the queue (drives requests into the
//            queue and the scheduler's out_ready)
//   slave  : the queue itself
interface mem_request_queue_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int OP_WIDTH      = 2
);
  logic                     in_valid;
  logic [OP_WIDTH-1:0]      in_opcode;
  logic [ADDRESS_WIDTH-1:0] in_address;
  logic                     in_ready;

  logic                     out_valid;
  logic [OP_WIDTH-1:0]      out_opcode;
  logic [ADDRESS_WIDTH-1:0] out_address;
  logic                     out_ready;

  modport master (
    output in_valid, in_opcode, in_address, out_ready,
    input  in_ready, out_valid, out_opcode, out_address
  );

  modport slave (
    input  in_valid, in_opcode, in_address, out_ready,
    output in_ready, out_valid, out_opcode, out_address
  );
endinterface

// File: rtl/mem_request_queue.sv
// mem_request_queue -- FIFO of memory requests between the parser and the
// scheduler, with optional per-entry age tracking for starvation detection.
//
// Circular buffer of DEPTH entries with first-word fall-through: the head
// entry is driven combinationally from storage, so a request enqueued into
// an empty queue is visible one cycle after its enqueue edge.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset (discards all entries)
//   q          mem_request_queue_if.slave: in_* request channel, out_* head
//   count      occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   oldest_age age of the head entry in cycles (0 when empty)
//   starved    head has waited at least STARVE_LIMIT cycles
//
// Build option:
//   QUEUE_AGE_EN  when defined, per-entry saturating age counters drive
//                 oldest_age / starved; when undefined both are tied to 0
//                 and no age storage exists.
module mem_request_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int OP_WIDTH      = 2,
  parameter int DEPTH         = 16,
  parameter int AGE_WIDTH     = 8,
  parameter int STARVE_LIMIT  = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  mem_request_queue_if.slave           q,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [AGE_WIDTH-1:0]         oldest_age,
  output logic                         starved
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int unsigned STARVE_U = STARVE_LIMIT;

`ifdef QUEUE_AGE_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            cnt;
  logic [OP_WIDTH-1:0]      op_mem   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];

  logic do_enq;
  logic do_deq;

  // Handshake flags come from registered occupancy only, so in_ready and
  // out_valid never depend combinationally on in_valid or out_ready.
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  assign q.in_ready  = !full;
  assign q.out_valid = !empty;

  assign do_enq = q.in_valid  && !full;
  assign do_deq = q.out_ready && !empty;

  // Fall-through head: no output register between storage and out_*.
  assign q.out_opcode  = op_mem[rd_ptr];
  assign q.out_address = addr_mem[rd_ptr];

  // DEPTH is a power of two, so the PW-bit pointers wrap DEPTH-1 -> 0 by
  // plain overflow.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register in
    // this block samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: payload storage is deliberately not reset; occupancy is defined
  // by the pointers and count alone, and clearing a RAM costs a reset net
  // per bit for nothing.
  always_ff @(posedge clk) begin
    if (!rst && do_enq) begin
      op_mem[wr_ptr]   <= q.in_opcode;
      addr_mem[wr_ptr] <= q.in_address;
    end
  end

`ifdef QUEUE_AGE_EN
  logic [AGE_WIDTH-1:0] age_mem  [DEPTH];
  logic [PW-1:0]        slot_ofs [DEPTH];
  logic [DEPTH-1:0]     occupied;

  // A slot holds a live entry when its distance from the read pointer
  // (modulo DEPTH) is below the occupancy.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so
    // no path can leave it unassigned and infer a latch.
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_ofs[i] = PW'(i) - rd_ptr;
      occupied[i] = (CW'(slot_ofs[i]) < cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) age_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_enq && (wr_ptr == PW'(i))) begin
          age_mem[i] <= '0;
        end else if (occupied[i] && (age_mem[i] != '1)) begin
          age_mem[i] <= age_mem[i] + 1'b1;
        end
      end
    end
  end

  assign oldest_age = empty ? '0 : age_mem[rd_ptr];
`else
  assign oldest_age = '0;
`endif

  assign starved = AGE_EN && !empty && (32'(oldest_age) >= STARVE_U);

endmodule
